// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: staggered multi-channel reset sequencer and run supervisor for the MIPS core.
// Sequence: HOLD -> RELEASE -> RUN -> DONE, with a halt detector and a run-cycle counter.
// Optional watchdog: define MIPS_RUN_CTRL_WDOG_EN to compile in the TIMEOUT comparator.
// Without it, timed_out is tied low and cycle_cnt saturates.
module mips_run_ctrl #(
    parameter int unsigned RST_CYCLES = 10,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned STAGGER    = 2,
    parameter int unsigned TIMEOUT    = 1000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt,
    output logic [NUM_CH-1:0] core_reset,
    output logic              running,
    output logic              done,
    output logic              timed_out,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam int unsigned HOLD_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned LAST_OFF = (NUM_CH - 1) * STAGGER;
    localparam int unsigned REL_W    = (LAST_OFF > 1) ? $clog2(LAST_OFF + 1) : 1;

    // Reject illegal configurations at elaboration time.
    if ((RST_CYCLES < 1) || (NUM_CH < 1) || (NUM_CH > 8) || (TIMEOUT < 1) ||
        ((CNT_W < 32) && (TIMEOUT >= (32'd1 << CNT_W)))) begin : g_bad_cfg
        $error("mips_run_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sync_q, sync_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [REL_W-1:0]    rel_cnt_q, rel_cnt_d;
    logic [NUM_CH-1:0]   core_reset_q, core_reset_d;
    logic                running_q, running_d;
    logic                done_q, done_d;
    logic                timed_out_q, timed_out_d;
    logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;

    logic [REL_W-1:0]    rel_next_c;
    logic                last_off_c;
    logic [NUM_CH-1:0]   ch_rst_c;
    logic                wdog_hit_c;
    logic [CNT_W-1:0]    cnt_inc_c;

`ifdef MIPS_RUN_CTRL_WDOG_EN
    // Watchdog fires on the last permitted RUN cycle; counter never reaches a wrap.
    always_comb begin
        wdog_hit_c = (cycle_cnt_q == CNT_W'(TIMEOUT - 1));
        cnt_inc_c  = cycle_cnt_q + CNT_W'(1);
    end
`else
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // No watchdog: the counter saturates instead of wrapping.
    always_comb begin
        wdog_hit_c = 1'b0;
        cnt_inc_c  = (cycle_cnt_q == CNT_MAX) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
    end
`endif

    // Reset release synchronizer: async assertion, two-flop deassertion.
    always_comb begin
        sync_d = {sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Per-channel release mask for the upcoming edge (offset 0 on RELEASE entry).
    always_comb begin
        rel_next_c = (state_q == S_RELEASE) ? rel_cnt_q + REL_W'(1) : '0;
        last_off_c = (32'(rel_next_c) >= LAST_OFF);
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            ch_rst_c[k] = (32'(rel_next_c) < (k * STAGGER));
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        rel_cnt_d    = rel_cnt_q;
        core_reset_d = core_reset_q;
        running_d    = running_q;
        done_d       = done_q;
        timed_out_d  = timed_out_q;
        cycle_cnt_d  = cycle_cnt_q;

        if (!sync_q[1]) begin
            state_d      = S_HOLD;
            hold_cnt_d   = '0;
            rel_cnt_d    = '0;
            core_reset_d = '1;
            running_d    = 1'b0;
            done_d       = 1'b0;
            timed_out_d  = 1'b0;
            cycle_cnt_d  = '0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    core_reset_d = '1;
                    if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
                        hold_cnt_d   = '0;
                        rel_cnt_d    = rel_next_c;
                        core_reset_d = ch_rst_c;
                        if (last_off_c) begin
                            state_d     = S_RUN;
                            running_d   = 1'b1;
                            cycle_cnt_d = '0;
                        end else begin
                            state_d = S_RELEASE;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                S_RELEASE: begin
                    rel_cnt_d    = rel_next_c;
                    core_reset_d = ch_rst_c;
                    if (last_off_c) begin
                        state_d     = S_RUN;
                        running_d   = 1'b1;
                        cycle_cnt_d = '0;
                    end
                end
                S_RUN: begin
                    if (start) begin
                        state_d      = S_HOLD;
                        hold_cnt_d   = '0;
                        core_reset_d = '1;
                        running_d    = 1'b0;
                        cycle_cnt_d  = '0;
                    end else if (halt) begin
                        state_d   = S_DONE;
                        running_d = 1'b0;
                        done_d    = 1'b1;
                    end else if (wdog_hit_c) begin
                        state_d     = S_DONE;
                        running_d   = 1'b0;
                        done_d      = 1'b1;
                        timed_out_d = 1'b1;
                    end else begin
                        cycle_cnt_d = cnt_inc_c;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_d      = S_HOLD;
                        hold_cnt_d   = '0;
                        core_reset_d = '1;
                        done_d       = 1'b0;
                        timed_out_d  = 1'b0;
                        cycle_cnt_d  = '0;
                    end
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_HOLD;
            hold_cnt_q   <= '0;
            rel_cnt_q    <= '0;
            core_reset_q <= '1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            cycle_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            rel_cnt_q    <= rel_cnt_d;
            core_reset_q <= core_reset_d;
            running_q    <= running_d;
            done_q       <= done_d;
            timed_out_q  <= timed_out_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    assign core_reset = core_reset_q;
    assign running    = running_q;
    assign done       = done_q;
    assign timed_out  = timed_out_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule
